// File: rtl/fcfs_req_queue.sv
// First-come-first-served ordering of four level requests feeding a 4-way arbiter.
// Slot 0 holds the oldest requester that is still active; dropped requesters are squeezed out.
module fcfs_req_queue #(
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              Rqst0,
  input  logic              Rqst1,
  input  logic              Rqst2,
  input  logic              Rqst3,
  output logic              Head_valid,
  output logic [1:0]        Head_id,
  output logic [2:0]        Count,
  output logic [3:0]        Pending,
  output logic [7:0]        Order,
  output logic [WAIT_W-1:0] Head_wait
);

  // Head_valid/Head_id are a plain level offer: no ready/ack, the arbiter
  // may sample them on any edge and they hold for the whole cycle.

  logic [1:0]        q      [4];
  logic [1:0]        nq     [4];
  logic [2:0]        cnt;
  logic [2:0]        n;
  logic [3:0]        pend;
  logic [3:0]        rq;
  logic [WAIT_W-1:0] hw;
  logic [WAIT_W-1:0] nxt_hw;

  always_comb begin
    rq = {Rqst3, Rqst2, Rqst1, Rqst0};
    for (int i = 0; i < 4; i++) nq[i] = 2'd0;
    n = 3'd0;
    // Retain still-active entries in their existing order, compacted toward slot 0.
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < cnt) && rq[q[i]]) begin
        nq[n[1:0]] = q[i];
        n          = n + 3'd1;
      end
    end
    // Append newly raised requests in ascending index order; pend mirrors queue membership.
    for (int i = 0; i < 4; i++) begin
      if (rq[i] && !pend[i] && (n < 3'd4)) begin
        nq[n[1:0]] = 2'(i);
        n          = n + 3'd1;
      end
    end
  end

  always_comb begin
    nxt_hw = '0;
    if (n != 3'd0 && cnt != 3'd0 && nq[0] == q[0]) begin
      if (hw != {WAIT_W{1'b1}}) nxt_hw = hw + WAIT_W'(1);
      else                      nxt_hw = hw;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) q[i] <= 2'd0;
      cnt  <= 3'd0;
      pend <= 4'd0;
      hw   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) q[i] <= nq[i];
      cnt  <= n;
      pend <= rq;
      hw   <= nxt_hw;
    end
  end

  assign Head_valid = (cnt != 3'd0);
  assign Head_id    = q[0];
  assign Count      = cnt;
  assign Pending    = pend;
  assign Order      = {q[3], q[2], q[1], q[0]};
  assign Head_wait  = hw;

endmodule

// File: tb/tb_fcfs_req_queue.sv
// Directed bench for fcfs_req_queue: hand-computed queue contents after each edge,
// sampled 1 ns after the rising edge.
module tb_fcfs_req_queue;

  logic       clk;
  logic       resetn;
  logic [3:0] rq;
  logic       head_valid;
  logic [1:0] head_id;
  logic [2:0] count;
  logic [3:0] pending;
  logic [7:0] order;
  logic [7:0] head_wait;

  int tests_run = 0;
  int fail_cnt  = 0;

  fcfs_req_queue #(.WAIT_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .Rqst0      (rq[0]),
    .Rqst1      (rq[1]),
    .Rqst2      (rq[2]),
    .Rqst3      (rq[3]),
    .Head_valid (head_valid),
    .Head_id    (head_id),
    .Count      (count),
    .Pending    (pending),
    .Order      (order),
    .Head_wait  (head_wait)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input string tag, input logic [7:0] e_order, input logic [2:0] e_cnt,
                          input logic [1:0] e_head, input logic e_valid, input logic [7:0] e_wait);
    check({tag, ".order"}, 32'(order), 32'(e_order));
    check({tag, ".count"}, 32'(count), 32'(e_cnt));
    check({tag, ".head_id"}, 32'(head_id), 32'(e_head));
    check({tag, ".head_valid"}, 32'(head_valid), 32'(e_valid));
    check({tag, ".head_wait"}, 32'(head_wait), 32'(e_wait));
  endtask

  initial begin
    resetn = 1'b0;
    rq     = 4'b0000;
    #12;
    expect_q("reset", 8'h00, 3'd0, 2'd0, 1'b0, 8'd0);
    check("reset.pending", 32'(pending), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tick();
    expect_q("idle", 8'h00, 3'd0, 2'd0, 1'b0, 8'd0);

    // sequential arrivals 2, 0, 3
    rq = 4'b0100; tick();
    expect_q("arr2", 8'h02, 3'd1, 2'd2, 1'b1, 8'd0);
    rq = 4'b0101; tick();
    expect_q("arr0", 8'h02, 3'd2, 2'd2, 1'b1, 8'd1);
    rq = 4'b1101; tick();
    expect_q("arr3", 8'h32, 3'd3, 2'd2, 1'b1, 8'd2);
    check("arr3.pending", 32'(pending), 32'hD);
    rq = 4'b1001; tick();
    expect_q("drop2", 8'h0C, 3'd2, 2'd0, 1'b1, 8'd0);
    check("drop2.pending", 32'(pending), 32'h9);
    rq = 4'b1101; tick();
    expect_q("rejoin2", 8'h2C, 3'd3, 2'd0, 1'b1, 8'd1);

    // asynchronous reset mid-queue, away from any clock edge
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    expect_q("async_rst", 8'h00, 3'd0, 2'd0, 1'b0, 8'd0);
    check("async_rst.pending", 32'(pending), 32'h0);
    rq = 4'b0000;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    expect_q("post_rst_idle", 8'h00, 3'd0, 2'd0, 1'b0, 8'd0);

    // simultaneous arrivals 3, 1, 0
    rq = 4'b1011; tick();
    expect_q("simul", 8'h34, 3'd3, 2'd0, 1'b1, 8'd0);
    check("simul.pending", 32'(pending), 32'hB);

    // build {1,3,2}, then withdraw 3 mid-queue while 0 arrives
    rq = 4'b1110; tick();
    expect_q("q132", 8'h2D, 3'd3, 2'd1, 1'b1, 8'd0);
    tick();
    expect_q("q132_hold", 8'h2D, 3'd3, 2'd1, 1'b1, 8'd1);
    rq = 4'b0111; tick();
    expect_q("mid_drop", 8'h09, 3'd3, 2'd1, 1'b1, 8'd2);
    check("mid_drop.pending", 32'(pending), 32'h7);

    // build {2,1}, then swap head while 3 arrives
    rq = 4'b0100; tick();
    expect_q("q2", 8'h02, 3'd1, 2'd2, 1'b1, 8'd0);
    rq = 4'b0110; tick();
    expect_q("q21", 8'h06, 3'd2, 2'd2, 1'b1, 8'd1);
    rq = 4'b1010; tick();
    expect_q("head_swap", 8'h0D, 3'd2, 2'd1, 1'b1, 8'd0);

    // a glitch low between edges is never sampled and keeps the place
    @(negedge clk);
    rq = 4'b1000;
    #2;
    rq = 4'b1010;
    tick();
    expect_q("glitch", 8'h0D, 3'd2, 2'd1, 1'b1, 8'd1);

    // drain, then saturate head wait with requester 0 alone
    rq = 4'b0000; tick();
    expect_q("drain", 8'h00, 3'd0, 2'd0, 1'b0, 8'd0);
    rq = 4'b0001; tick();
    expect_q("sat_start", 8'h00, 3'd1, 2'd0, 1'b1, 8'd0);
    repeat (254) tick();
    check("sat_254", 32'(head_wait), 32'd254);
    tick();
    check("sat_255", 32'(head_wait), 32'd255);
    repeat (44) tick();
    expect_q("sat_hold", 8'h00, 3'd1, 2'd0, 1'b1, 8'd255);
    rq = 4'b0000; tick();
    expect_q("reentry_drop", 8'h00, 3'd0, 2'd0, 1'b0, 8'd0);
    rq = 4'b0001; tick();
    expect_q("reentry", 8'h00, 3'd1, 2'd0, 1'b1, 8'd0);
    tick();
    check("reentry.wait1", 32'(head_wait), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fcfs_req_queue.md
# fcfs_req_queue

First-come-first-served request ordering queue that sits directly upstream of the 4-way bus arbiter. It samples the four request lines every clock and records the order in which they became active. It presents the oldest still-active requester to the arbiter as the head entry. Requesters that drop their request are removed from any position, and the remaining order is preserved.

## Interface
Parameters:
- WAIT_W, 8, width of the head wait counter (saturating)

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  reset, asynchronous, active-low
- Rqst0..Rqst3  input  1 each  level request from requester 0..3
- Head_valid  output  1  queue non-empty
- Head_id  output  2  index of oldest active requester
- Count  output  3  number of queued requesters, 0..4
- Pending  output  4  bit i set while requester i is queued
- Order  output  8  queue contents; {slot3,slot2,slot1,slot0}, 2 bits each, slot0 = head
- Head_wait  output  WAIT_W  cycles the current head has held the head slot

## Operation
- Storage: 4 slots q[0..3] of 2-bit IDs, plus a 3-bit count. Pending is a 4-bit vector. No requester is ever queued twice, so overflow is impossible.
- Each rising clk edge computes the next queue in two steps:
  - Retain: existing slots whose requester's Rqst is high keep their relative order and are compacted toward slot0. Slots whose Rqst is low are discarded, whether at the head or mid-queue.
  - Append: each requester with Rqst high and Pending low is appended after the retained entries, in ascending index order (0 before 3).
- Pending[i] after the edge = Rqst_i sampled at the edge.
- Count = retained + appended. It never exceeds 4.
- Head_valid = (Count != 0). Head_id = q[0]. Head_id = 0 when empty.
- Order slots at index >= Count are driven as 0.
- Head_wait:
  - Cleared to 0 on any edge where the head ID or Head_valid changes.
  - Otherwise increments while Head_valid, saturating at 2^WAIT_W-1.
  - Held at 0 while empty.
- Simultaneous events:
  - Head drops while a new request arrives in the same edge: the head is removed, slot1 becomes the head, and the new request goes to the tail.
  - A requester that drops and re-asserts between edges without being sampled low keeps its place.
  - A requester sampled low for one edge loses its place. It re-enters at the tail on its next sampled high.
- Reset (asynchronous, any time, including mid-queue):
  - All outputs and internal state go to 0: Head_valid=0, Head_id=0, Count=0, Pending=0, Order=0, Head_wait=0.
  - At the first edge after resetn rises, all high requests are appended in index order.

## Timing
- All outputs are registered; there is no combinational path from Rqst to any output.
- Latency: Rqst_i sampled high at edge k is visible in Pending/Order/Count after edge k. If the queue was empty, Head_valid=1 and Head_id=i after edge k.
- Removal latency: a request sampled low at edge k has its slot removed after edge k. The next head is presented in the same cycle.
- The arbiter may sample Head_id/Head_valid on any edge. Both are stable for the whole cycle.
- Head_wait value after edge k equals the number of edges since the current head first appeared, where 0 means it appeared at edge k.

## Test plan
- Reset/idle: assert resetn=0 mid-run with 3 entries queued -> all outputs 0 immediately, without waiting for clk. Release reset with no requests -> outputs stay 0.
- Sequential arrivals: raise Rqst2, Rqst0, Rqst3 on three consecutive edges -> Order=8'b00_11_00_10 with Count=3 and Head_id=2. Drop Rqst2 -> Head_id=0, Count=2.
- Simultaneous arrivals: Rqst3, Rqst1, Rqst0 all rise at the same edge from empty -> Order slots {0,1,3}, Head_id=0, Count=3, Pending=4'b1011.
- Mid-queue withdrawal plus arrival: queue {1,3,2}. Drop Rqst3 and raise Rqst0 at the same edge -> queue {1,2,0}, Count=3, Head_id=1, Head_wait keeps counting.
- Head swap plus new arrival: queue {2,1}. Drop Rqst2 and raise Rqst3 at the same edge -> queue {1,3}, Head_id=1, Head_wait=0 after that edge.
- Re-entry and saturation:
  - Hold Rqst0 alone for 300 cycles -> Head_wait saturates at 255.
  - Drop Rqst0 for one sampled edge -> queue empty, Head_wait=0.
  - Re-raise Rqst0 -> Head_wait restarts from 0.
